// File: rtl/vga_buffer_arbiter.sv
// Single-port arbiter for the 600x28-bit screen buffer: display fetches take strict priority,
// and AXI-lite writes and reads alternate round-robin in the slots that remain.
module vga_buffer_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 28,
    parameter int STRB_WIDTH = 4,
    parameter int MAX_WAIT   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vr_req_i,
    input  logic [ADDR_WIDTH-1:0] vr_addr_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  w_req_i,
    input  logic [ADDR_WIDTH-1:0] w_addr_i,
    input  logic [STRB_WIDTH-1:0] w_strb_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  w_ack_o,
    input  logic                  r_req_i,
    input  logic [ADDR_WIDTH-1:0] r_addr_i,
    output logic                  r_ack_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_valid_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [STRB_WIDTH-1:0] mem_strb_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  starve_o
);

    localparam int CNT_WIDTH = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_WRITE,
        GNT_READ
    } grant_t;

    // Tag bit 0 marks a display fetch, bit 1 an AXI read.
    localparam logic [1:0] TAG_DISP = 2'b01;
    localparam logic [1:0] TAG_AXI  = 2'b10;

    grant_t                w_grant;
    logic                  w_wrEligible;
    logic                  w_rdEligible;
    logic                  w_axiGrant;
    logic                  w_axiWaiting;

    logic                  r_lastAxi;
    logic                  r_wAck;
    logic                  r_rAck;
    logic                  r_memEn;
    logic                  r_memWe;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [STRB_WIDTH-1:0] r_memStrb;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic [1:0]            r_tag1;
    logic [1:0]            r_tag2;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_doutValid;
    logic [DATA_WIDTH-1:0] r_rData;
    logic                  r_rValid;
    logic [CNT_WIDTH-1:0]  r_waitCnt;
    logic                  r_starve;

    // A requester acked this cycle may still hold its req high, so it sits out one slot.
    always_comb begin
        w_wrEligible = w_req_i && !r_wAck;
        w_rdEligible = r_req_i && !r_rAck;
        w_grant      = GNT_IDLE;
        if (vr_req_i) begin
            w_grant = GNT_DISP;
        end else if (w_wrEligible && w_rdEligible) begin
            w_grant = r_lastAxi ? GNT_WRITE : GNT_READ;
        end else if (w_wrEligible) begin
            w_grant = GNT_WRITE;
        end else if (w_rdEligible) begin
            w_grant = GNT_READ;
        end
        w_axiGrant   = (w_grant == GNT_WRITE) || (w_grant == GNT_READ);
        w_axiWaiting = (w_wrEligible || w_rdEligible) && !w_axiGrant;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lastAxi  <= 1'b1;
            r_wAck     <= 1'b0;
            r_rAck     <= 1'b0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memStrb  <= '0;
            r_memWdata <= '0;
            r_tag1     <= 2'b00;
        end else begin
            r_wAck  <= 1'b0;
            r_rAck  <= 1'b0;
            r_memEn <= 1'b0;
            r_tag1  <= 2'b00;
            case (w_grant)
                GNT_DISP: begin
                    r_memEn   <= 1'b1;
                    r_memWe   <= 1'b0;
                    r_memAddr <= vr_addr_i;
                    r_memStrb <= '0;
                    r_tag1    <= TAG_DISP;
                end
                GNT_WRITE: begin
                    r_memEn    <= 1'b1;
                    r_memWe    <= 1'b1;
                    r_memAddr  <= w_addr_i;
                    r_memStrb  <= w_strb_i;
                    r_memWdata <= din_i;
                    r_wAck     <= 1'b1;
                    r_lastAxi  <= 1'b0;
                end
                GNT_READ: begin
                    r_memEn   <= 1'b1;
                    r_memWe   <= 1'b0;
                    r_memAddr <= r_addr_i;
                    r_memStrb <= '0;
                    r_rAck    <= 1'b1;
                    r_tag1    <= TAG_AXI;
                    r_lastAxi <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // The memory answers one cycle after the command; the tag tells us who asked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tag2      <= 2'b00;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_rData     <= '0;
            r_rValid    <= 1'b0;
        end else begin
            r_tag2      <= r_tag1;
            r_doutValid <= r_tag2[0];
            r_rValid    <= r_tag2[1];
            if (r_tag2[0]) begin
                r_dout <= mem_rdata_i;
            end
            if (r_tag2[1]) begin
                r_rData <= mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_waitCnt <= '0;
            r_starve  <= 1'b0;
        end else if (w_axiGrant) begin
            r_waitCnt <= '0;
        end else if (w_axiWaiting && (r_waitCnt != CNT_MAX)) begin
            r_waitCnt <= r_waitCnt + 1'b1;
            if (r_waitCnt == CNT_LAST) begin
                r_starve <= 1'b1;
            end
        end
    end

    assign w_ack_o      = r_wAck;
    assign r_ack_o      = r_rAck;
    assign mem_en_o     = r_memEn;
    assign mem_we_o     = r_memWe;
    assign mem_addr_o   = r_memAddr;
    assign mem_strb_o   = r_memStrb;
    assign mem_wdata_o  = r_memWdata;
    assign dout_o       = r_dout;
    assign dout_valid_o = r_doutValid;
    assign r_data_o     = r_rData;
    assign r_valid_o    = r_rValid;
    assign starve_o     = r_starve;

endmodule

// File: tb/tb_vga_buffer_arbiter.sv
// Bench for vga_buffer_arbiter: a behavioural RAM answers the command port while a
// transaction-level model predicts grants, acks, read returns and the starvation flag.
module tb_vga_buffer_arbiter;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        vrReq;
    logic [9:0]  vrAddr;
    logic [27:0] dout;
    logic        doutValid;
    logic        wReq;
    logic [9:0]  wAddr;
    logic [3:0]  wStrb;
    logic [27:0] din;
    logic        wAck;
    logic        rReq;
    logic [9:0]  rAddr;
    logic        rAck;
    logic [27:0] rData;
    logic        rValid;
    logic        memEn;
    logic        memWe;
    logic [9:0]  memAddr;
    logic [3:0]  memStrb;
    logic [27:0] memWdata;
    logic [27:0] memRdata;
    logic        starve;

    vga_buffer_arbiter #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(28),
        .STRB_WIDTH(4),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .vr_req_i(vrReq),
        .vr_addr_i(vrAddr),
        .dout_o(dout),
        .dout_valid_o(doutValid),
        .w_req_i(wReq),
        .w_addr_i(wAddr),
        .w_strb_i(wStrb),
        .din_i(din),
        .w_ack_o(wAck),
        .r_req_i(rReq),
        .r_addr_i(rAddr),
        .r_ack_o(rAck),
        .r_data_o(rData),
        .r_valid_o(rValid),
        .mem_en_o(memEn),
        .mem_we_o(memWe),
        .mem_addr_o(memAddr),
        .mem_strb_o(memStrb),
        .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata),
        .starve_o(starve)
    );

    always #20 clk = ~clk;

    function automatic logic [27:0] initVal(input int a);
        if (a == 5) return 28'h0ABCDEF;
        if (a == 10) return 28'h0000000;
        return 28'((a * 32'h0013579) ^ 32'h05A5A5A5);
    endfunction

    function automatic logic [27:0] mergeLanes(input logic [27:0] old, input logic [27:0] nw,
                                               input logic [3:0] strb);
        logic [27:0] res;
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[7*k +: 7] = nw[7*k +: 7];
        end
        return res;
    endfunction

    // Behavioural single-port screen RAM with one cycle read latency.
    bit [27:0]   ramData [0:1023];
    bit [1023:0] ramWritten;

    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) begin
                ramData[memAddr]    <= mergeLanes(ramWritten[memAddr] ? ramData[memAddr] : initVal(int'(memAddr)),
                                                  memWdata, memStrb);
                ramWritten[memAddr] <= 1'b1;
            end else begin
                memRdata <= ramWritten[memAddr] ? ramData[memAddr] : initVal(int'(memAddr));
            end
        end
    end

    // Reference model state.
    typedef struct {
        int          due;
        bit          disp;
        logic [27:0] data;
    } retT;

    retT         retQ[$];
    bit [27:0]   goldData [0:1023];
    bit [1023:0] goldWritten;
    bit          mWAck;
    bit          mRAck;
    bit          mLastRead;
    int          mWait;
    bit          mStarve;
    int          cycleNum;
    bit          expEn;
    bit          expWe;
    logic [9:0]  expAddr;
    logic [3:0]  expStrb;
    logic [27:0] expWdata;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    function automatic logic [27:0] goldRead(input logic [9:0] a);
        return goldWritten[a] ? goldData[a] : initVal(int'(a));
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNum);
        end
    endtask

    task automatic modelReset();
        retQ.delete();
        mWAck     = 1'b0;
        mRAck     = 1'b0;
        mLastRead = 1'b1;
        mWait     = 0;
        mStarve   = 1'b0;
        expEn     = 1'b0;
    endtask

    // Decide what the coming edge should grant from the requests now on the inputs.
    task automatic predictEdge();
        bit wCand, rCand, doWrite, doRead;
        wCand   = wReq && !mWAck;
        rCand   = rReq && !mRAck;
        doWrite = 1'b0;
        doRead  = 1'b0;
        expEn   = 1'b0;
        if (vrReq) begin
            expEn   = 1'b1;
            expWe   = 1'b0;
            expAddr = vrAddr;
            expStrb = 4'h0;
            retQ.push_back('{due: cycleNum + 3, disp: 1'b1, data: goldRead(vrAddr)});
        end else if (wCand && rCand) begin
            doWrite = mLastRead;
            doRead  = !mLastRead;
        end else begin
            doWrite = wCand;
            doRead  = rCand;
        end
        if (doWrite) begin
            expEn    = 1'b1;
            expWe    = 1'b1;
            expAddr  = wAddr;
            expStrb  = wStrb;
            expWdata = din;
            goldData[wAddr]    = mergeLanes(goldRead(wAddr), din, wStrb);
            goldWritten[wAddr] = 1'b1;
            mLastRead = 1'b0;
        end
        if (doRead) begin
            expEn   = 1'b1;
            expWe   = 1'b0;
            expAddr = rAddr;
            expStrb = 4'h0;
            retQ.push_back('{due: cycleNum + 3, disp: 1'b0, data: goldRead(rAddr)});
            mLastRead = 1'b1;
        end
        mWAck = doWrite;
        mRAck = doRead;
        if (doWrite || doRead) begin
            mWait = 0;
        end else if (wCand || rCand) begin
            if (mWait < MAX_WAIT) mWait++;
            if (mWait == MAX_WAIT) mStarve = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycleNum++;
    endtask

    task automatic checkOutput();
        bit          expDV, expRV;
        logic [27:0] expData;
        retT         r;
        expDV   = 1'b0;
        expRV   = 1'b0;
        expData = '0;
        if (retQ.size() > 0 && retQ[0].due == cycleNum) begin
            r       = retQ.pop_front();
            expDV   = r.disp;
            expRV   = !r.disp;
            expData = r.data;
        end
        checkVal("mem_en", 32'(memEn), 32'(expEn));
        if (expEn) begin
            checkVal("mem_we", 32'(memWe), 32'(expWe));
            checkVal("mem_addr", 32'(memAddr), 32'(expAddr));
            checkVal("mem_strb", 32'(memStrb), 32'(expStrb));
            if (expWe) checkVal("mem_wdata", 32'(memWdata), 32'(expWdata));
        end
        checkVal("w_ack", 32'(wAck), 32'(mWAck));
        checkVal("r_ack", 32'(rAck), 32'(mRAck));
        checkVal("dout_valid", 32'(doutValid), 32'(expDV));
        checkVal("r_valid", 32'(rValid), 32'(expRV));
        if (expDV) checkVal("dout", 32'(dout), 32'(expData));
        if (expRV) checkVal("r_data", 32'(rData), 32'(expData));
        checkVal("starve", 32'(starve), 32'(mStarve));
    endtask

    task automatic runCycle();
        predictEdge();
        tick();
        checkOutput();
    endtask

    task automatic applyStimulus(input bit v, input logic [9:0] va,
                                 input bit w, input logic [9:0] wa, input logic [3:0] ws,
                                 input logic [27:0] wd, input bit r, input logic [9:0] ra);
        vrReq  = v;
        vrAddr = va;
        wReq   = w;
        wAddr  = wa;
        wStrb  = ws;
        din    = wd;
        rReq   = r;
        rAddr  = ra;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_mem_en"}, 32'(memEn), 32'h0);
        checkVal({tag, "_mem_addr"}, 32'(memAddr), 32'h0);
        checkVal({tag, "_acks"}, 32'({wAck, rAck}), 32'h0);
        checkVal({tag, "_valids"}, 32'({doutValid, rValid}), 32'h0);
        checkVal({tag, "_dout"}, 32'(dout), 32'h0);
        checkVal({tag, "_r_data"}, 32'(rData), 32'h0);
        checkVal({tag, "_starve"}, 32'(starve), 32'h0);
    endtask

    initial begin
        cycleNum = 0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;

        // Display fetch latency.
        applyStimulus(1, 10'd5, 0, 0, 0, 0, 0, 0);
        runCycle();
        checkVal("disp_cmd", 32'({memEn, memWe, memAddr}), 32'({1'b1, 1'b0, 10'd5}));
        vrReq = 1'b0;
        runCycle();
        runCycle();
        checkVal("disp_valid", 32'(doutValid), 32'h1);
        checkVal("disp_data", 32'(dout), 32'h0ABCDEF);

        // Strobed write then read back.
        applyStimulus(0, 0, 1, 10'd10, 4'b0101, 28'hFFFFFFF, 0, 0);
        runCycle();
        checkVal("strb_wack", 32'(wAck), 32'h1);
        wReq = 1'b0;
        runCycle();
        rReq = 1'b1;
        rAddr = 10'd10;
        runCycle();
        checkVal("strb_rack", 32'(rAck), 32'h1);
        rReq = 1'b0;
        runCycle();
        runCycle();
        checkVal("strb_rvalid", 32'(rValid), 32'h1);
        checkVal("strb_rdata", 32'(rData), 32'h01FC07F);

        // Round-robin with both AXI requests held.
        applyStimulus(0, 0, 1, 10'd40, 4'hF, 28'h1234567, 1, 10'd41);
        for (int i = 0; i < 8; i++) begin
            runCycle();
            checkVal("rr_wack", 32'(wAck), 32'((i % 2) == 0));
            checkVal("rr_rack", 32'(rAck), 32'((i % 2) == 1));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) runCycle();

        // Display burst blocks a pending read until it starves.
        applyStimulus(1, 10'd100, 0, 0, 0, 0, 1, 10'd7);
        for (int i = 0; i < 20; i++) begin
            vrAddr = 10'(100 + i);
            runCycle();
            checkVal("burst_rack", 32'(rAck), 32'h0);
            checkVal("burst_starve", 32'(starve), 32'(i >= 15));
        end
        vrReq = 1'b0;
        runCycle();
        checkVal("burst_served", 32'(rAck), 32'h1);
        rReq = 1'b0;
        for (int i = 0; i < 3; i++) runCycle();
        checkVal("starve_sticky", 32'(starve), 32'h1);

        // Display and write in the same cycle.
        applyStimulus(1, 10'd200, 1, 10'd201, 4'hF, 28'h7654321, 0, 0);
        runCycle();
        checkVal("coll_first", 32'({memEn, memWe, wAck}), 32'({1'b1, 1'b0, 1'b0}));
        vrReq = 1'b0;
        runCycle();
        checkVal("coll_second", 32'({memEn, memWe, wAck}), 32'({1'b1, 1'b1, 1'b1}));
        wReq = 1'b0;
        for (int i = 0; i < 3; i++) runCycle();

        // Reset in the middle of an outstanding AXI read.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10'd20);
        runCycle();
        rReq = 1'b0;
        #10;
        rst = 1'b1;
        #1;
        checkAllZero("async_rst");
        modelReset();
        tick();
        checkAllZero("held_rst");
        rst = 1'b0;
        applyStimulus(0, 0, 1, 10'd30, 4'hF, 28'h0F0F0F0, 1, 10'd31);
        runCycle();
        checkVal("post_rst_first", 32'({wAck, rAck, rValid}), 32'({1'b1, 1'b0, 1'b0}));
        wReq = 1'b0;
        runCycle();
        checkVal("post_rst_second", 32'({rAck, rValid}), 32'({1'b1, 1'b0}));
        rReq = 1'b0;
        for (int i = 0; i < 3; i++) runCycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            vrReq  = ($urandom_range(0, 3) == 0);
            vrAddr = 10'($urandom_range(0, 1023));
            if (!wReq || mWAck) begin
                wReq  = $urandom_range(0, 1) == 1;
                wAddr = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
                wStrb = 4'($urandom_range(0, 15));
                din   = 28'($urandom);
            end
            if (!rReq || mRAck) begin
                rReq  = $urandom_range(0, 1) == 1;
                rAddr = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
            end
            runCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) runCycle();
        checkVal("drain_empty", 32'(retQ.size()), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
